// File: rtl/synapse_fanout_engine.sv
// synapse_fanout_engine
//   Buffers incoming axon spikes in a FIFO and expands each one into
//   per-neuron weighted events, one neuron per cycle, from an internal
//   read-first signed weight RAM. The output uses valid/ready backpressure.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   enable                     lets the fan-out FSM advance / issue reads
//   spike_in_*                 valid/ready input of axon ids (ready = FIFO not full)
//   spike_out_*                valid/ready output of {axon, neuron, weight} events
//   fanout_done                one-cycle pulse when a fan-out has fully drained
//   weight_we/addr_*/data      weight RAM write port
//   busy                       FSM not idle or FIFO not empty
//   fifo_count                 FIFO occupancy
//   drop_count                 saturating count of spikes offered while full
module synapse_fanout_engine #(
  parameter int NUM_AXONS       = 64,
  parameter int NUM_NEURONS     = 64,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int SKIP_ZERO       = 1,
  parameter int AXON_ID_WIDTH   = $clog2(NUM_AXONS),
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
  parameter int CNT_WIDTH       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              spike_in_valid,
  output logic                              spike_in_ready,
  input  logic [AXON_ID_WIDTH-1:0]          spike_in_axon_id,
  output logic                              spike_out_valid,
  input  logic                              spike_out_ready,
  output logic [AXON_ID_WIDTH-1:0]          spike_out_axon_id,
  output logic [NEURON_ID_WIDTH-1:0]        spike_out_neuron_id,
  output logic signed [WEIGHT_WIDTH-1:0]    spike_out_weight,
  output logic                              fanout_done,
  input  logic                              weight_we,
  input  logic [AXON_ID_WIDTH-1:0]          weight_addr_axon,
  input  logic [NEURON_ID_WIDTH-1:0]        weight_addr_neuron,
  input  logic signed [WEIGHT_WIDTH-1:0]    weight_data,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              fifo_count,
  output logic [15:0]                       drop_count
);

  localparam int MEM_DEPTH = NUM_AXONS * NUM_NEURONS;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]          NN_A      = ADDR_W'(NUM_NEURONS);
  localparam logic [NEURON_ID_WIDTH-1:0] LAST_NEUR = NEURON_ID_WIDTH'(NUM_NEURONS - 1);
  localparam logic [CNT_WIDTH-1:0]       FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  // ---------------- input FIFO ----------------
  logic [AXON_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;

  assign fifo_full      = (fifo_count == FULL_CNT);
  assign fifo_empty     = (fifo_count == '0);
  assign spike_in_ready = !fifo_full;
  assign push           = spike_in_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= spike_in_axon_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (spike_in_valid && fifo_full && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 1'b1;
    end
  end

  // ---------------- fan-out control ----------------
  logic [AXON_ID_WIDTH-1:0]   cur_axon;
  logic [NEURON_ID_WIDTH-1:0] ncnt;
  logic                       advance, pipe_move, rd_issue;
  logic                       m_valid, m_keep;

  assign advance   = enable && (!spike_out_valid || spike_out_ready);
  // A pending output may still be consumed while enable is low; the
  // stage behind it then slides forward without new reads being issued.
  assign pipe_move = advance || (spike_out_valid && spike_out_ready);

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    rd_issue    = 1'b0;
    fanout_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          pop        = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (advance) begin
          rd_issue = 1'b1;
          if (ncnt == LAST_NEUR) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!m_valid && !spike_out_valid) begin
          // gated so a reset cycle never reports an abandoned fan-out
          fanout_done = rst_n;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_axon <= '0;
      ncnt     <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        cur_axon <= fifo_mem[rd_ptr];
        ncnt     <= '0;
      end else if (rd_issue) begin
        ncnt <= ncnt + 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE) || !fifo_empty;

  // ---------------- weight RAM + memory stage ----------------
  logic signed [WEIGHT_WIDTH-1:0] wmem [MEM_DEPTH];
  logic [ADDR_W-1:0]              waddr, raddr;
  logic signed [WEIGHT_WIDTH-1:0] m_data;
  logic [AXON_ID_WIDTH-1:0]       m_axon;
  logic [NEURON_ID_WIDTH-1:0]     m_neuron;

  assign waddr = ADDR_W'(weight_addr_axon) * NN_A + ADDR_W'(weight_addr_neuron);
  assign raddr = ADDR_W'(cur_axon) * NN_A + ADDR_W'(ncnt);

  // Write and read in one block with non-blocking updates: a same-address
  // collision returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (weight_we) wmem[waddr] <= weight_data;
    if (rd_issue) begin
      m_data   <= wmem[raddr];
      m_axon   <= cur_axon;
      m_neuron <= ncnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         m_valid <= 1'b0;
    else if (pipe_move) m_valid <= rd_issue;
  end

  // ---------------- output register ----------------
  assign m_keep = m_valid && !((SKIP_ZERO != 0) && (m_data == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_out_valid     <= 1'b0;
      spike_out_axon_id   <= '0;
      spike_out_neuron_id <= '0;
      spike_out_weight    <= '0;
    end else if (pipe_move) begin
      spike_out_valid <= m_keep;
      if (m_keep) begin
        spike_out_axon_id   <= m_axon;
        spike_out_neuron_id <= m_neuron;
        spike_out_weight    <= m_data;
      end
    end
  end

endmodule
